// File: rtl/sha3_pkg.sv
// Shared types and helpers for the SHA-3 core: Keccak state layout, digest select,
// output serializer FSM states and digest byte-length lookup.
package sha3_pkg;

  localparam int STATE_BITS = 1600;

  typedef logic [4:0][4:0][63:0] keccak_state_t;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } digest_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Byte length of the streamed output; full mode dumps the whole 200-byte state.
  function automatic logic [7:0] digest_bytes(input digest_sel_t sel, input logic full);
    logic [7:0] len;
    if (full) begin
      len = 8'd200;
    end else begin
      case (sel)
        SHA3_224: len = 8'd28;
        SHA3_256: len = 8'd32;
        SHA3_384: len = 8'd48;
        default:  len = 8'd64;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/sha3_state_flatten.sv
// Packs the [x][y] Keccak lane array into a flat 1600-bit vector, lane x+5y at bit 64*(x+5y).
// Purely combinational; shared with the input absorber.
module sha3_state_flatten
  import sha3_pkg::*;
(
  input  keccak_state_t           lanes,
  output logic [STATE_BITS-1:0]   flat
);

  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_col
      assign flat[64*(x+5*y) +: 64] = lanes[x][y];
    end
  end

endmodule

// File: rtl/sha3_out_serializer.sv
// AXI-Stream output stage: captures the final Keccak state and streams the digest in
// DATA_WIDTH-bit beats. Define SHA_OUT_BACK2BACK_EN to allow capture on the last-beat handshake.
module sha3_out_serializer
  import sha3_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  keccak_state_t             S_STATE,
  input  logic [1:0]                S_TUSER,
  input  logic                      S_FULL,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST
);

  // state | meaning
  // IDLE  | no digest held, S_READY high, waiting for the permutation engine
  // SEND  | streaming beats, TVALID high, counter holds beats still to send

  localparam int BYTES = DATA_WIDTH / 8;

  ser_state_t            state_q, state_d;
  logic [STATE_BITS-1:0] flat;
  logic [STATE_BITS-1:0] shreg_q;
  logic [7:0]            len;
  logic [7:0]            n_beats;
  logic [7:0]            beats_q;
  logic [3:0]            n_rem;
  logic [3:0]            rem_q;
  logic                  load;
  logic                  shift;
  logic                  ready_c;
  logic                  last_beat;
  logic [BYTES-1:0]      keep;
  logic [DATA_WIDTH-1:0] data;

  sha3_state_flatten u_flatten (
    .lanes (S_STATE),
    .flat  (flat)
  );

  assign len       = digest_bytes(digest_sel_t'(S_TUSER), S_FULL);
  assign n_beats   = 8'((32'(len) + BYTES - 1) / BYTES);
  assign n_rem     = 4'(32'(len) % BYTES);
  assign last_beat = (beats_q == 8'd1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (S_VALID) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (M_AXIS_TREADY) begin
          shift = 1'b1;
          if (last_beat) begin
            state_d = IDLE;
`ifdef SHA_OUT_BACK2BACK_EN
            // Reload on the final handshake so TVALID never drops between digests.
            ready_c = 1'b1;
            if (S_VALID) begin
              load    = 1'b1;
              state_d = SEND;
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      shreg_q <= '0;
      beats_q <= '0;
      rem_q   <= '0;
    end else if (load) begin
      shreg_q <= flat;
      beats_q <= n_beats;
      rem_q   <= n_rem;
    end else if (shift) begin
      shreg_q <= shreg_q >> DATA_WIDTH;
      beats_q <= beats_q - 8'd1;
    end
  end

  // Bytes past the digest length on a partial last beat are masked to zero.
  always_comb begin
    keep = '0;
    data = '0;
    if (state_q == SEND) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!last_beat || rem_q == 4'd0 || b < 32'(rem_q)) begin
          keep[b]        = 1'b1;
          data[8*b +: 8] = shreg_q[8*b +: 8];
        end
      end
    end
  end

  assign S_READY       = ready_c & ~ARESET;
  assign M_AXIS_TVALID = (state_q == SEND);
  assign M_AXIS_TLAST  = (state_q == SEND) && last_beat;
  assign M_AXIS_TKEEP  = keep;
  assign M_AXIS_TDATA  = data;

endmodule

// File: tb/tb_sha3_out_serializer.sv
// Bench for sha3_out_serializer: four widths driven in parallel, each checked every cycle
// against a byte-level model of the digest stream.
`timescale 1ns/1ps
module tb_sha3_out_serializer;
  import sha3_pkg::*;

  localparam int ND = 4;
`ifdef SHA_OUT_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          aclk;
  logic          areset;
  logic [ND-1:0] s_valid;
  logic [ND-1:0] s_ready;
  keccak_state_t s_state;
  logic [1:0]    s_tuser;
  logic          s_full;
  logic          m_tready;
  logic [63:0]   td64;
  logic [31:0]   td32;
  logic [15:0]   td16;
  logic [7:0]    td8;
  logic [7:0]    tk64;
  logic [3:0]    tk32;
  logic [1:0]    tk16;
  logic [0:0]    tk8;
  logic [ND-1:0] tv;
  logic [ND-1:0] tl;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  sha3_out_serializer #(.DATA_WIDTH(64)) u_dut64 (
    .ACLK(aclk), .ARESET(areset), .S_VALID(s_valid[0]), .S_READY(s_ready[0]),
    .S_STATE(s_state), .S_TUSER(s_tuser), .S_FULL(s_full),
    .M_AXIS_TDATA(td64), .M_AXIS_TKEEP(tk64), .M_AXIS_TVALID(tv[0]),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(tl[0]));

  sha3_out_serializer #(.DATA_WIDTH(32)) u_dut32 (
    .ACLK(aclk), .ARESET(areset), .S_VALID(s_valid[1]), .S_READY(s_ready[1]),
    .S_STATE(s_state), .S_TUSER(s_tuser), .S_FULL(s_full),
    .M_AXIS_TDATA(td32), .M_AXIS_TKEEP(tk32), .M_AXIS_TVALID(tv[1]),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(tl[1]));

  sha3_out_serializer #(.DATA_WIDTH(16)) u_dut16 (
    .ACLK(aclk), .ARESET(areset), .S_VALID(s_valid[2]), .S_READY(s_ready[2]),
    .S_STATE(s_state), .S_TUSER(s_tuser), .S_FULL(s_full),
    .M_AXIS_TDATA(td16), .M_AXIS_TKEEP(tk16), .M_AXIS_TVALID(tv[2]),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(tl[2]));

  sha3_out_serializer #(.DATA_WIDTH(8)) u_dut8 (
    .ACLK(aclk), .ARESET(areset), .S_VALID(s_valid[3]), .S_READY(s_ready[3]),
    .S_STATE(s_state), .S_TUSER(s_tuser), .S_FULL(s_full),
    .M_AXIS_TDATA(td8), .M_AXIS_TKEEP(tk8), .M_AXIS_TVALID(tv[3]),
    .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(tl[3]));

  int            total;
  int            bad;
  int            cyc;
  int            rdy_mode;
  logic          nxt_rst;
  logic          rst_done;
  logic [ND-1:0] pend;
  keccak_state_t nxt_state;
  logic [1:0]    nxt_tuser;
  logic          nxt_full;

  logic [63:0]   exp_data [ND][200];
  logic [7:0]    exp_keep [ND][200];
  int            exp_n    [ND];
  int            exp_head [ND];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", tag, got, want, cyc);
    end
  endtask

  function automatic int dw_of(input int j);
    case (j)
      0:       return 64;
      1:       return 32;
      2:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] obs_data(input int j);
    case (j)
      0:       return td64;
      1:       return 64'(td32);
      2:       return 64'(td16);
      default: return 64'(td8);
    endcase
  endfunction

  function automatic logic [63:0] obs_keep(input int j);
    case (j)
      0:       return 64'(tk64);
      1:       return 64'(tk32);
      2:       return 64'(tk16);
      default: return 64'(tk8);
    endcase
  endfunction

  function automatic logic [7:0] state_byte(input int idx);
    int lane;
    lane = idx / 8;
    return s_state[lane % 5][lane / 5][8*(idx % 8) +: 8];
  endfunction

  function automatic keccak_state_t rand_state();
    keccak_state_t st;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        st[x][y] = {$urandom, $urandom};
    return st;
  endfunction

  function automatic logic [ND-1:0] busy_mask();
    logic [ND-1:0] m;
    for (int j = 0; j < ND; j++) m[j] = exp_head[j] < exp_n[j];
    return m;
  endfunction

  // Expected beat list for the state/mode currently on the inputs.
  task automatic push_txn(input int j);
    int len, bpb, idx;
    len = s_full ? 200 : (s_tuser == 2'd0) ? 28 : (s_tuser == 2'd1) ? 32 : (s_tuser == 2'd2) ? 48 : 64;
    bpb = dw_of(j) / 8;
    exp_n[j]    = (len + bpb - 1) / bpb;
    exp_head[j] = 0;
    for (int k = 0; k < exp_n[j]; k++) begin
      exp_data[j][k] = '0;
      exp_keep[j][k] = '0;
      for (int b = 0; b < bpb; b++) begin
        idx = k * bpb + b;
        if (idx < len) begin
          exp_data[j][k][8*b +: 8] = state_byte(idx);
          exp_keep[j][k][b]        = 1'b1;
        end
      end
    end
  endtask

  task automatic sample();
    for (int j = 0; j < ND; j++) begin
      bit    busy, last, exp_rdy;
      string w;
      w       = $sformatf("%0d", dw_of(j));
      busy    = exp_head[j] < exp_n[j];
      last    = busy && (exp_head[j] == exp_n[j] - 1);
      exp_rdy = !areset && (!busy || (B2B && last && m_tready));
      check_val({"tvalid_w", w}, 64'(tv[j]), 64'(busy));
      check_val({"s_ready_w", w}, 64'(s_ready[j]), 64'(exp_rdy));
      if (busy) begin
        check_val({"tdata_w", w}, obs_data(j), exp_data[j][exp_head[j]]);
        check_val({"tkeep_w", w}, obs_keep(j), 64'(exp_keep[j][exp_head[j]]));
        check_val({"tlast_w", w}, 64'(tl[j]), 64'(last));
      end else begin
        check_val({"idle_tlast_w", w}, 64'(tl[j]), 64'd0);
        if (rst_done) begin
          check_val({"rst_tkeep_w", w}, obs_keep(j), 64'd0);
          check_val({"rst_tdata_w", w}, obs_data(j), 64'd0);
        end
      end
      if (busy && m_tready) exp_head[j]++;
      if (s_valid[j] && exp_rdy) begin
        push_txn(j);
        pend[j] = 1'b0;
      end
      if (areset) begin
        exp_n[j]    = 0;
        exp_head[j] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    rst_done = areset;
    areset   = nxt_rst;
    s_valid  = pend;
    s_state  = nxt_state;
    s_tuser  = nxt_tuser;
    s_full   = nxt_full;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_tready = ($urandom_range(0, 9) < 7);
    endcase
    cyc++;
    #1;
    sample();
  endtask

  task automatic run_txn(input keccak_state_t st, input logic [1:0] tu, input logic fu);
    int n;
    n         = 0;
    nxt_state = st;
    nxt_tuser = tu;
    nxt_full  = fu;
    pend      = '1;
    while (pend != '0 && n < 3000) begin
      tick();
      n++;
    end
    check_val("capture_wait", 64'(pend), 64'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_mask() != '0 && n < 3000);
    check_val("drain", 64'(busy_mask()), 64'd0);
  endtask

  task automatic pulse_reset();
    nxt_rst = 1'b1;
    tick();
    nxt_rst = 1'b0;
  endtask

  initial begin
    keccak_state_t pat;
    int n;
    areset   = 1'b1;
    s_valid  = '0;
    s_state  = '0;
    s_tuser  = '0;
    s_full   = 1'b0;
    m_tready = 1'b0;
    total    = 0;
    bad      = 0;
    cyc      = 0;
    rdy_mode = 0;
    rst_done = 1'b0;
    nxt_rst  = 1'b1;
    for (int j = 0; j < ND; j++) begin
      exp_n[j]    = 0;
      exp_head[j] = 0;
    end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        pat[x][y] = 64'h0101010101010101 * 64'(x + 5 * y + 1);

    // S_VALID held high through reset must not be captured.
    nxt_state = pat;
    nxt_tuser = 2'd1;
    nxt_full  = 1'b0;
    pend      = '1;
    repeat (3) tick();
    nxt_rst = 1'b0;

    run_txn(pat, 2'd1, 1'b0);
    drain();

    run_txn(rand_state(), 2'd0, 1'b0);
    drain();

    rdy_mode = 1;
    run_txn(rand_state(), 2'd0, 1'b1);
    drain();
    rdy_mode = 0;

    run_txn(rand_state(), 2'd3, 1'b0);
    n = 0;
    while (exp_head[1] < 6 && n < 100) begin
      tick();
      n++;
    end
    pulse_reset();
    run_txn(rand_state(), 2'd3, 1'b0);
    drain();

    run_txn(rand_state(), 2'd1, 1'b0);
    run_txn(rand_state(), 2'd1, 1'b0);
    drain();

    for (int t = 0; t < 25; t++) begin
      rdy_mode = $urandom_range(0, 2);
      run_txn(rand_state(), 2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 20)) tick();
        pulse_reset();
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
